// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM states, grant encodings and
// the full-word byte-enable used for instruction fetches.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

    localparam logic [3:0] SEL_FULL = 4'b1111;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one single-ported SRAM between instruction fetch
// and load/store; the data port has fixed priority, accesses last WAIT_CYCLES.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stall_o,

    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stall_o,

    output logic        sram_ce_o,
    output logic        sram_we_o,
    output logic [3:0]  sram_sel_o,
    output logic [31:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t       state, state_next;
    grant_t           grant, grant_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic             load_mem;
    logic             load_if;
    logic             capture;

    logic             req_we;
    logic [3:0]       req_sel;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [31:0]      result;

    logic             busy;
    logic             done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= GNT_IF;
            cnt   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            cnt   <= cnt_next;
        end
    end

    // DONE hands the SRAM straight to the other port so alternating traffic
    // never pays an IDLE bubble; the port just served is not re-granted.
    always_comb begin
        state_next = state;
        grant_next = grant;
        cnt_next   = cnt;
        load_mem   = 1'b0;
        load_if    = 1'b0;
        capture    = 1'b0;

        case (state)
            IDLE: begin
                if (mem_ce_i) begin
                    load_mem = 1'b1;
                end else if (if_ce_i) begin
                    load_if = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (grant == GNT_IF && mem_ce_i) begin
                    load_mem = 1'b1;
                end else if (grant == GNT_MEM && if_ce_i) begin
                    load_if = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load_mem) begin
            grant_next = GNT_MEM;
            cnt_next   = CNT_LOAD;
            state_next = BUSY;
        end else if (load_if) begin
            grant_next = GNT_IF;
            cnt_next   = CNT_LOAD;
            state_next = BUSY;
        end
    end

    // Requests are latched at grant time so the SRAM sees a stable command
    // even if the requester changes or drops its inputs mid-access.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_we    <= 1'b0;
            req_sel   <= 4'b0000;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
            result    <= 32'd0;
        end else begin
            if (load_mem) begin
                req_we    <= mem_we_i;
                req_sel   <= mem_sel_i;
                req_addr  <= mem_addr_i;
                req_wdata <= mem_data_i;
            end else if (load_if) begin
                req_we    <= 1'b0;
                req_sel   <= SEL_FULL;
                req_addr  <= if_addr_i;
                req_wdata <= 32'd0;
            end
            if (capture) begin
                result <= sram_rdata_i;
            end
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    assign sram_ce_o    = busy;
    assign sram_we_o    = busy & req_we;
    assign sram_sel_o   = busy ? req_sel   : 4'b0000;
    assign sram_addr_o  = busy ? req_addr  : 32'd0;
    assign sram_wdata_o = busy ? req_wdata : 32'd0;

    // Write completions return zero; only reads forward the captured word.
    assign if_data_o  = (done && grant == GNT_IF  && !req_we) ? result : 32'd0;
    assign mem_data_o = (done && grant == GNT_MEM && !req_we) ? result : 32'd0;

    assign if_stall_o  = if_ce_i  & ~(done && grant == GNT_IF);
    assign mem_stall_o = mem_ce_i & ~(done && grant == GNT_MEM);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random traffic
// compared every cycle against a timestamp-based transaction model.
module tb_sram_arbiter;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_data_o;
    logic        if_stall_o;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_data_o;
    logic        mem_stall_o;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata;

    logic [31:0] sram_mem  [0:255];
    logic [31:0] model_mem [0:255];

    int          total;
    int          bad;
    int          cyc;

    bit          m_act;
    bit          m_port;
    int          m_start;
    bit          m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_result;

    bit          last_done_if;
    bit          last_done_mem;
    logic [5:0]  o_ctrl;
    logic [31:0] o_addr;
    logic [31:0] o_if_data;
    logic [31:0] o_mem_data;
    logic        o_if_stall;
    logic        o_mem_stall;
    int          we_seen;
    logic [3:0]  last_we_sel;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_ce_i      (if_ce),
        .if_addr_i    (if_addr),
        .if_data_o    (if_data_o),
        .if_stall_o   (if_stall_o),
        .mem_ce_i     (mem_ce),
        .mem_we_i     (mem_we),
        .mem_sel_i    (mem_sel),
        .mem_addr_i   (mem_addr),
        .mem_data_i   (mem_wdata),
        .mem_data_o   (mem_data_o),
        .mem_stall_o  (mem_stall_o),
        .sram_ce_o    (sram_ce_o),
        .sram_we_o    (sram_we_o),
        .sram_sel_o   (sram_sel_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata)
    );

    assign sram_rdata = sram_mem[sram_addr_o[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit ice, input logic [31:0] iaddr,
                                 input bit mce, input bit mwe, input logic [3:0] msel,
                                 input logic [31:0] maddr, input logic [31:0] mdata);
        if_ce     = ice;
        if_addr   = iaddr;
        mem_ce    = mce;
        mem_we    = mwe;
        mem_sel   = msel;
        mem_addr  = maddr;
        mem_wdata = mdata;
    endtask

    // A granted transaction occupies the SRAM for cycles [start, start+W) and
    // completes at start+W; its write takes effect and its read value is fixed
    // when it is granted, since accesses never overlap.
    task automatic startTxn(input bit port);
        m_act   = 1'b1;
        m_port  = port;
        m_start = cyc + 1;
        if (port) begin
            m_we    = mem_we;
            m_sel   = mem_sel;
            m_addr  = mem_addr;
            m_wdata = mem_wdata;
        end else begin
            m_we    = 1'b0;
            m_sel   = 4'b1111;
            m_addr  = if_addr;
            m_wdata = 32'd0;
        end
        m_result = model_mem[m_addr[9:2]];
        if (m_we) model_mem[m_addr[9:2]] = mergeBytes(model_mem[m_addr[9:2]], m_wdata, m_sel);
    endtask

    task automatic stepCycle();
        bit         busy;
        bit         done;
        logic [5:0] e_ctrl;
        logic [1:0] e_stall;
        @(negedge clk);
        busy = m_act && cyc >= m_start && cyc < m_start + W;
        done = m_act && cyc == m_start + W;
        o_ctrl      = {sram_ce_o, sram_we_o, sram_sel_o};
        o_addr      = sram_addr_o;
        o_if_data   = if_data_o;
        o_mem_data  = mem_data_o;
        o_if_stall  = if_stall_o;
        o_mem_stall = mem_stall_o;
        e_ctrl  = busy ? {1'b1, m_we, m_sel} : 6'd0;
        e_stall = {if_ce & ~(done & ~m_port), mem_ce & ~(done & m_port)};
        checkOutput("sram_ctrl", 32'(o_ctrl), 32'(e_ctrl));
        checkOutput("sram_addr", o_addr, busy ? m_addr : 32'd0);
        checkOutput("sram_wdata", sram_wdata_o, busy ? m_wdata : 32'd0);
        checkOutput("if_data", o_if_data, (done && !m_port && !m_we) ? m_result : 32'd0);
        checkOutput("mem_data", o_mem_data, (done && m_port && !m_we) ? m_result : 32'd0);
        checkOutput("stalls", 32'({o_if_stall, o_mem_stall}), 32'(e_stall));
        if (o_ctrl[4]) begin
            we_seen++;
            last_we_sel = o_ctrl[3:0];
        end
        if (sram_ce_o && sram_we_o)
            sram_mem[sram_addr_o[9:2]] = mergeBytes(sram_mem[sram_addr_o[9:2]], sram_wdata_o, sram_sel_o);
        last_done_if  = done && !m_port;
        last_done_mem = done && m_port;
        @(posedge clk);
        if (rst) begin
            m_act = 1'b0;
        end else if (!busy) begin
            if (done && !m_port && mem_ce)     startTxn(1'b1);
            else if (done && m_port && if_ce)  startTxn(1'b0);
            else if (done)                     m_act = 1'b0;
            else if (mem_ce)                   startTxn(1'b1);
            else if (if_ce)                    startTxn(1'b0);
            else                               m_act = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic waitDone(input bit is_mem, output int stall_cycles);
        stall_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (is_mem ? !o_mem_stall : !o_if_stall) return;
            stall_cycles++;
        end
    endtask

    task automatic goIdle();
        applyStimulus(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
        stepCycle();
        stepCycle();
    endtask

    initial begin
        int n;
        int mem_done_at;
        int if_done_at;
        total = 0;
        bad   = 0;
        cyc   = 0;
        m_act = 1'b0;
        m_port = 1'b0;
        m_start = 0;
        we_seen = 0;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i]  = 32'd0;
            model_mem[i] = 32'd0;
        end
        sram_mem[8'h40]  = 32'h2402000A;
        model_mem[8'h40] = 32'h2402000A;
        sram_mem[8'h41]  = 32'h8C430004;
        model_mem[8'h41] = 32'h8C430004;

        rst = 1'b1;
        applyStimulus(0, 32'd0, 0, 0, 4'h0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        stepCycle();
        stepCycle();
        checkOutput("reset_ctrl", 32'(o_ctrl), 32'd0);
        checkOutput("reset_if_data", o_if_data, 32'd0);
        checkOutput("reset_mem_data", o_mem_data, 32'd0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] fetch only");
        applyStimulus(1, 32'h100, 0, 0, 4'h0, 32'd0, 32'd0);
        waitDone(1'b0, n);
        checkOutput("fetch_stall_cycles", 32'(n), 32'(W + 1));
        checkOutput("fetch_data", o_if_data, 32'h2402000A);
        goIdle();

        $display("[TB] partial write and readback");
        we_seen = 0;
        applyStimulus(0, 32'd0, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF);
        waitDone(1'b1, n);
        checkOutput("write_we_cycles", 32'(we_seen), 32'(W));
        checkOutput("write_sel", 32'(last_we_sel), 32'h3);
        checkOutput("write_data_out", o_mem_data, 32'd0);
        applyStimulus(0, 32'd0, 1, 0, 4'b1111, 32'h200, 32'd0);
        waitDone(1'b1, n);
        checkOutput("readback", o_mem_data, 32'h0000BEEF);
        goIdle();

        $display("[TB] simultaneous requests");
        applyStimulus(1, 32'h104, 1, 0, 4'b1111, 32'h200, 32'd0);
        mem_done_at = -1;
        if_done_at  = -1;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (mem_ce && !o_mem_stall) begin
                checkOutput("both_mem_data", o_mem_data, 32'h0000BEEF);
                mem_done_at = i;
                mem_ce = 1'b0;
            end
            if (!o_if_stall) begin
                if_done_at = i;
                checkOutput("both_if_data", o_if_data, 32'h8C430004);
                break;
            end
        end
        checkOutput("both_mem_done_at", 32'(mem_done_at), 32'(W + 1));
        checkOutput("both_if_done_at", 32'(if_done_at), 32'(2 * (W + 1)));
        goIdle();

        $display("[TB] fetch flush");
        applyStimulus(1, 32'h100, 0, 0, 4'h0, 32'd0, 32'd0);
        stepCycle();
        stepCycle();
        if_ce = 1'b0;
        for (int i = 0; i < W + 1; i++) begin
            stepCycle();
            checkOutput("flush_if_stall", 32'(o_if_stall), 32'd0);
        end
        applyStimulus(1, 32'h104, 0, 0, 4'h0, 32'd0, 32'd0);
        waitDone(1'b0, n);
        checkOutput("after_flush_stall_cycles", 32'(n), 32'(W + 1));
        checkOutput("after_flush_data", o_if_data, 32'h8C430004);
        goIdle();

        $display("[TB] reset during write");
        applyStimulus(0, 32'd0, 1, 1, 4'b1111, 32'h208, 32'h12345678);
        stepCycle();
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("rstmid_ctrl", 32'(o_ctrl), 32'd0);
        checkOutput("rstmid_addr", o_addr, 32'd0);
        checkOutput("rstmid_mem_stall", 32'(o_mem_stall), 32'd1);
        waitDone(1'b1, n);
        checkOutput("rstmid_restart_cycles", 32'(n), 32'(W));
        applyStimulus(0, 32'd0, 1, 0, 4'b1111, 32'h208, 32'd0);
        waitDone(1'b1, n);
        checkOutput("rstmid_readback", o_mem_data, 32'h12345678);
        goIdle();

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            if (if_ce) begin
                if (last_done_if || $urandom_range(0, 19) == 0) if_ce = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                if_ce   = 1'b1;
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (mem_ce) begin
                if (last_done_mem || $urandom_range(0, 19) == 0) mem_ce = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                mem_ce    = 1'b1;
                mem_we    = 1'($urandom_range(0, 1));
                mem_sel   = 4'($urandom_range(1, 15));
                mem_addr  = 32'($urandom_range(0, 63)) << 2;
                mem_wdata = $urandom;
            end
            rst = ($urandom_range(0, 99) == 0);
            stepCycle();
        end
        rst = 1'b0;
        goIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Shares one single-ported synchronous SRAM between two requesters: the instruction-fetch port (`pc_reg`/`if_id` side) and the load/store port (`mem` stage side).
- Issues one SRAM transaction at a time and holds it for a fixed number of wait cycles.
- Returns read data to the requester and drives a per-port stall so the pipeline holds the requesting stage until its access completes.
- Sits between the CPU top level's rom/mem buses and the external memory; the stall outputs feed the pipeline stall logic.

## Interface
Parameters:
- `WAIT_CYCLES`, 1, cycles `sram_ce_o` is held per access; legal range ≥1.

Ports (all data/address buses 32 bits):
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_ce_i`  in  1  fetch request
- `if_addr_i`  in  32  fetch byte address
- `if_data_o`  out  32  fetched word; valid in fetch completion cycle
- `if_stall_o`  out  1  hold the fetch stage
- `mem_ce_i`  in  1  data request
- `mem_we_i`  in  1  1 = write
- `mem_sel_i`  in  4  byte enables
- `mem_addr_i`  in  32  data byte address
- `mem_data_i`  in  32  write data
- `mem_data_o`  out  32  read word; valid in data completion cycle
- `mem_stall_o`  out  1  hold the memory stage
- `sram_ce_o`, `sram_we_o`  out  1  SRAM enable, write enable
- `sram_sel_o`  out  4  SRAM byte enables; 4'b1111 for fetch
- `sram_addr_o`, `sram_wdata_o`  out  32  SRAM address, write data
- `sram_rdata_i`  in  32  SRAM read data

## Operation
- FSM states: IDLE, BUSY, DONE. A grant register (GNT_IF/GNT_MEM) records the port being served.
- IDLE:
  - If `mem_ce_i`, latch the data request, grant GNT_MEM, load the counter with WAIT_CYCLES-1, go to BUSY.
  - Else if `if_ce_i`, latch the fetch request (we=0, sel=1111), grant GNT_IF, load the counter, go to BUSY.
  - Data port has fixed priority over the fetch port.
- BUSY:
  - `sram_*` outputs are driven from the latched request; the counter decrements.
  - At counter==0, capture `sram_rdata_i` into the result register (captured on writes as well, but not forwarded) and go to DONE.
- DONE:
  - The granted port's `*_data_o` presents the result register; reads only, writes return 0.
  - Arbitration ignores the just-completed port's `ce`. If the other port's `ce` is high, latch it and go to BUSY; otherwise go to IDLE.
- Stalls (combinational):
  - `if_stall_o = if_ce_i & ~(state==DONE & grant==GNT_IF)`
  - `mem_stall_o = mem_ce_i & ~(state==DONE & grant==GNT_MEM)`
- Requesters hold their address, data and control stable while stalled; the arbiter uses latched copies regardless.
- Requester drops `ce` mid-BUSY (flush): the transaction completes, so a write is still performed. Read data is discarded and no stall is raised for that port.
- Outputs not owned by the current state are 0: `sram_*` outside BUSY, and `*_data_o` outside DONE for the granted read.

## Timing
- Reset (rst high at an edge):
  - Next cycle: state IDLE, grant GNT_IF, counter 0, result 0; all `sram_*` outputs 0, both `*_data_o` 0.
  - Stalls still follow `ce` (high if `ce` is high).
  - Reset mid-BUSY abandons the access; a partial write is permitted.
- Uncontended access, request seen in IDLE at cycle t:
  - BUSY for cycles t+1 … t+WAIT_CYCLES.
  - DONE at cycle t+WAIT_CYCLES+1: stall low, data valid.
  - Stall is high for WAIT_CYCLES+1 cycles.
- Back-to-back accesses to alternate ports have no IDLE bubble: DONE is followed directly by BUSY.
- Both ports requesting in IDLE: data is served first, then fetch from DONE. Fetch completes 2·(WAIT_CYCLES+1) cycles after t.

## Structure
- Shared defines package holds the state encodings (IDLE/BUSY/DONE), the grant constants (GNT_IF/GNT_MEM) and the full-word select constant 4'b1111.
- Single module. The wait counter is `$clog2(WAIT_CYCLES+1)` bits wide, inline, with no sub-module.

## Test plan
- Fetch only, WAIT_CYCLES=2, `if_addr_i`=0x100, SRAM word 0x2402000A: stall high 3 cycles; `if_data_o`=0x2402000A in cycle 4 with stall low.
- Write `mem_sel_i`=4'b0011, addr 0x200, data 0xDEADBEEF: `sram_we_o`=1 and sel=0011 for 2 cycles; `mem_data_o`=0; a readback of 0x200 returns 0x0000BEEF (SRAM preloaded 0).
- Simultaneous fetch 0x104 and read 0x200 in IDLE: data served first, fetch BUSY starts directly after data DONE; fetch stall low only at t+6.
- `if_ce_i` dropped during BUSY: access completes; `if_stall_o`=0 throughout; next IDLE fetch is not affected.
- `rst` asserted mid-BUSY of a write: next cycle state IDLE and all `sram_*`=0; a request pending after reset restarts from the latch.
- WAIT_CYCLES=1 stream of 4 fetches: each fetch completes 2 cycles after issue; verify no lost or duplicated grants.
